// File: rtl/phase_bank.sv
// -----------------------------------------------------------------------------
// phase_bank
// Double-buffered per-channel phase store. Host command words write phases
// into a shadow bank. A COMMIT copies the whole shadow bank into the active
// bank in a single cycle, so the drive generators never see a partial update.
//
// Optional feature macro: PHASE_BANK_SYNC_COMMIT_EN
//   defined   : COMMIT waits in PEND for the next period_sync pulse
//   undefined : COMMIT goes straight to APPLY, PEND is not built,
//               period_sync is unused, commit_pending is tied to 0
//
// Parameters
//   NUM_CHANNELS   number of channels (1..256)
//   PHASE_W        phase width in bits (1..8)
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   phase_parse_en single-cycle strobe, latest_data valid
//   latest_data    command word {ignored[31:18], op[17:16], phase[15:8], addr[7:0]}
//   period_sync    drive-period start pulse (sync-commit build only)
//   phases_active  active bank, channel k at [k*PHASE_W +: PHASE_W]
//   commit_pending a commit is waiting for period_sync
//   commit_done    one-cycle pulse the cycle after the active bank updates
//   drop_count     saturating count of rejected words
// -----------------------------------------------------------------------------
module phase_bank #(
    parameter int unsigned NUM_CHANNELS = 64,
    parameter int unsigned PHASE_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            phase_parse_en,
    input  logic [31:0]                     latest_data,
    input  logic                            period_sync,
    output logic [NUM_CHANNELS*PHASE_W-1:0] phases_active,
    output logic                            commit_pending,
    output logic                            commit_done,
    output logic [15:0]                     drop_count
);

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CNT_W   = 16;
    localparam logic [1:0]  OP_NONE   = 2'b00;
    localparam logic [1:0]  OP_WRITE  = 2'b01;
    localparam logic [1:0]  OP_COMMIT = 2'b10;
    localparam logic [1:0]  OP_CLEAR  = 2'b11;

`ifdef PHASE_BANK_SYNC_COMMIT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd2
    } state_e;
`endif

    state_e                                 state_q;
    logic [NUM_CHANNELS-1:0][PHASE_W-1:0]   shadow_q;
    logic [NUM_CHANNELS-1:0][PHASE_W-1:0]   shadow_d;
    logic [NUM_CHANNELS-1:0][PHASE_W-1:0]   active_q;
    logic                                   done_q;
    logic [CNT_W-1:0]                       drop_q;
    logic [CNT_W-1:0]                       drop_d;

    // Command word decode
    logic [1:0]        op_c;
    logic [7:0]        phase_c;
    logic [ADDR_W-1:0] addr_c;
    logic              addr_ok_c;
    logic              wr_c;
    logic              clr_c;
    logic              commit_c;
    logic              drop_c;

    assign op_c      = latest_data[17:16];
    assign phase_c   = latest_data[15:8];
    assign addr_c    = latest_data[7:0];
    assign addr_ok_c = (9'(addr_c) < 9'(NUM_CHANNELS));
    assign wr_c      = phase_parse_en && (op_c == OP_WRITE) && addr_ok_c;
    assign clr_c     = phase_parse_en && (op_c == OP_CLEAR);
    assign commit_c  = phase_parse_en && (op_c == OP_COMMIT);
    assign drop_c    = phase_parse_en &&
                       ((op_c == OP_NONE) || ((op_c == OP_WRITE) && !addr_ok_c));

    // Shadow bank next state: CLEAR wipes it, WRITE updates one entry
    always_comb begin
        shadow_d = shadow_q;
        if (clr_c) begin
            shadow_d = '0;
        end else if (wr_c) begin
            for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
                if (addr_c == ADDR_W'(k)) begin
                    shadow_d[k] = phase_c[PHASE_W-1:0];
                end
            end
        end
    end

    // Saturating reject counter
    always_comb begin
        drop_d = drop_q;
        if (drop_c && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

`ifdef PHASE_BANK_SYNC_COMMIT_EN
    logic pending_q;
    assign commit_pending = pending_q;

    logic unused_c;
    assign unused_c = &{1'b0, latest_data[31:18], phase_c};
`else
    assign commit_pending = 1'b0;

    logic unused_c;
    assign unused_c = &{1'b0, latest_data[31:18], phase_c, period_sync};
`endif

    // Commit FSM plus bank/counter registers; COMMIT outside IDLE is absorbed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            done_q    <= 1'b0;
            drop_q    <= '0;
`ifdef PHASE_BANK_SYNC_COMMIT_EN
            pending_q <= 1'b0;
`endif
        end else begin
            shadow_q <= shadow_d;
            drop_q   <= drop_d;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (commit_c) begin
`ifdef PHASE_BANK_SYNC_COMMIT_EN
                        state_q   <= ST_PEND;
                        pending_q <= 1'b1;
`else
                        state_q   <= ST_APPLY;
`endif
                    end
                end
`ifdef PHASE_BANK_SYNC_COMMIT_EN
                ST_PEND: begin
                    if (period_sync) begin
                        state_q   <= ST_APPLY;
                        pending_q <= 1'b0;
                    end
                end
`endif
                ST_APPLY: begin
                    // Copies shadow as registered now; same-cycle writes land next commit
                    active_q <= shadow_q;
                    done_q   <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign phases_active = active_q;
    assign commit_done   = done_q;
    assign drop_count    = drop_q;

endmodule

// File: doc/phase_bank.md
# phase_bank

Double-buffered per-channel phase store sitting directly downstream of the host command receiver. It consumes the receiver's `phase_parse_en` strobe and 32-bit `latest_data` word, writes phases into a shadow bank, and on a commit command copies the whole shadow bank atomically into the active bank. The active bank drives the transducer drive generators, so they never see a partially updated pattern.

## Interface
- `NUM_CHANNELS`, default 64: number of transducer channels, range 1–256.
- `PHASE_W`, default 8: phase width in bits, range 1–8.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `phase_parse_en` in 1: single-cycle strobe meaning `latest_data` is valid.
- `latest_data` in 32: command word from the receiver.
- `period_sync` in 1: single-cycle pulse at the start of each drive period. Used only with `PHASE_BANK_SYNC_COMMIT_EN`.
- `phases_active` out NUM_CHANNELS*PHASE_W: active bank, flattened. Channel k occupies bits [k*PHASE_W +: PHASE_W].
- `commit_pending` out 1: a commit is waiting for `period_sync`.
- `commit_done` out 1: one-cycle pulse in the cycle after the active bank is updated.
- `drop_count` out 16: saturating count of rejected words.

## Operation
- Word decode, on `phase_parse_en`=1 only:
  - `op` = `latest_data[17:16]`
  - `phase` = `latest_data[15:8]`
  - `addr` = `latest_data[7:0]`
  - bits [31:18] are ignored.
- `op`=2'b01 WRITE: `shadow[addr]` <= `phase[PHASE_W-1:0]`. If `addr` >= NUM_CHANNELS, the write is dropped and `drop_count` increments.
- `op`=2'b10 COMMIT: request copy of shadow to active (see Configuration).
- `op`=2'b11 CLEAR: every shadow entry <= 0. The active bank is untouched.
- `op`=2'b00: dropped, and `drop_count` increments.
- `drop_count` saturates at 16'hFFFF.
- FSM states:
  - IDLE: COMMIT goes to APPLY, or to PEND if sync-commit is enabled.
  - PEND: `period_sync` goes to APPLY.
  - APPLY: copy shadow to active, then return to IDLE.
- A COMMIT received while in PEND or APPLY is absorbed. No second commit is queued.
- WRITE and CLEAR are accepted in every state.
- A commit copies the shadow contents as registered at the start of the APPLY cycle. A WRITE arriving in that same cycle lands in shadow only and appears at the next commit.
- Reset values: shadow=0, `phases_active`=0, `commit_pending`=0, `commit_done`=0, `drop_count`=0, state IDLE.
- Reset during PEND or APPLY discards the commit.

## Timing
- WRITE or CLEAR strobe at cycle N: shadow updated at the N+1 edge.
- COMMIT without sync, strobe at cycle N:
  - APPLY during N+1.
  - `phases_active` valid at N+2.
  - `commit_done`=1 during N+2.
- COMMIT with sync:
  - `commit_pending`=1 from N+1.
  - `period_sync` at cycle M (M ≥ N+1) gives APPLY at M+1, `phases_active` updated at M+2, `commit_done` at M+2.
  - `commit_pending` falls at M+1.
- `period_sync` in the same cycle as the COMMIT strobe does not count. Only later pulses count.
- `period_sync` outside PEND is ignored.
- Back-to-back strobes on every cycle are fully supported. No backpressure exists.

## Configuration
- `PHASE_BANK_SYNC_COMMIT_EN` defined: COMMIT waits in PEND for the next `period_sync`, so pattern changes align to the drive-period boundary.
- Not defined:
  - COMMIT goes straight to APPLY and the PEND state is not built.
  - `period_sync` is unused.
  - `commit_pending` is tied to 0.

## Test plan
- Reset, then WRITE `latest_data`=32'h0001_5A03 and COMMIT 32'h0002_0000 (no sync): `phases_active` channel 3 = 8'h5A two cycles after COMMIT, with a 1-cycle `commit_done`. All other channels stay 0.
- Burst of WRITEs to addresses 0..NUM_CHANNELS-1 with phase=addr on consecutive cycles, then COMMIT: every channel k reads k. Before the commit, `phases_active` remains all zero.
- WRITE to addr 8'd64 (NUM_CHANNELS=64) and an `op`=0 word: `drop_count`=2, shadow unchanged. Forcing 65 537 drops leaves `drop_count`=16'hFFFF.
- With sync enabled: COMMIT, wait 10 cycles, assert `period_sync`:
  - `commit_pending` is high for those cycles.
  - `phases_active` changes exactly 2 cycles after `period_sync`.
  - A second COMMIT while pending yields a single `commit_done`.
- WRITE ch0=8'hFF in the APPLY cycle: active ch0 keeps the old value. A following COMMIT makes it 8'hFF.
- CLEAR then COMMIT gives all zeros. Asserting `rst` during PEND clears `commit_pending`, and no `commit_done` follows a later `period_sync`.
